// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: WB always wins, LU results wait in a small FIFO
// and drain into idle write-port cycles; starvation raises ws_hold.
//
// state | meaning
// IDLE  | FIFO empty
// PEND  | FIFO non-empty, counting ungranted head cycles
// HOLD  | head starved, ws_hold asserted to force a bubble
module rf_wport_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  ws_rf_we,
  input  logic [4:0]  ws_rf_waddr,
  input  logic [31:0] ws_rf_wdata,
  input  logic [31:0] ws_pc,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [3:0]  lu_we,
  input  logic [4:0]  lu_waddr,
  input  logic [31:0] lu_wdata,
  input  logic [31:0] lu_pc,
  output logic        ws_hold,
  output logic [31:0] pend_mask,
  output logic [3:0]  rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_WAIT) + 1;
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);
  localparam logic [CW-1:0] WAIT_ONE  = CW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PEND = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [3:0]  q_we    [DEPTH];
  logic [4:0]  q_waddr [DEPTH];
  logic [31:0] q_wdata [DEPTH];
  logic [31:0] q_pc    [DEPTH];
  logic [DEPTH-1:0] q_vld;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next;
  logic [CW-1:0] wait_cnt;
  logic [1:0]    state;

  logic ws_grant, push, push_store, pop;

  assign ws_grant   = |ws_rf_we;
  assign push       = lu_valid && lu_ready;
  // Results that would write nothing are accepted but dropped.
  assign push_store = push && (|lu_we) && (|lu_waddr);
  assign pop        = !reset && !ws_grant && (count != '0);

  always_comb begin
    count_next = count;
    case ({push_store, pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      q_vld    <= '0;
      lu_ready <= 1'b1;
    end else begin
      count    <= count_next;
      lu_ready <= (count_next != FULL_CNT);
      if (push_store) begin
        wr_ptr        <= wr_ptr + PTR_ONE;
        q_vld[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr        <= rd_ptr + PTR_ONE;
        q_vld[rd_ptr] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_store) begin
      q_we[wr_ptr]    <= lu_we;
      q_waddr[wr_ptr] <= lu_waddr;
      q_wdata[wr_ptr] <= lu_wdata;
      q_pc[wr_ptr]    <= lu_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          wait_cnt <= '0;
          if (push_store) state <= S_PEND;
        end
        S_PEND: begin
          if (pop) begin
            wait_cnt <= '0;
            if (count_next == '0) state <= S_IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            state <= S_HOLD;
          end else begin
            wait_cnt <= wait_cnt + WAIT_ONE;
          end
        end
        S_HOLD: begin
          if (pop) begin
            wait_cnt <= '0;
            state    <= (count_next == '0) ? S_IDLE : S_PEND;
          end
        end
        default: begin
          state    <= S_IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  assign ws_hold = (state == S_HOLD);

  always_comb begin
    rf_we       = 4'h0;
    rf_waddr    = ws_rf_waddr;
    rf_wdata    = ws_rf_wdata;
    debug_wb_pc = ws_pc;
    if (!reset) begin
      if (ws_grant) begin
        rf_we = ws_rf_we;
      end else if (count != '0) begin
        rf_we       = q_we[rd_ptr];
        rf_waddr    = q_waddr[rd_ptr];
        rf_wdata    = q_wdata[rd_ptr];
        debug_wb_pc = q_pc[rd_ptr];
      end
    end
  end

  // Entry stays visible through its grant cycle so ID keeps interlocking until the write lands.
  logic [31:0] pm;
  always_comb begin
    pm = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_vld[i]) pm[q_waddr[i]] = 1'b1;
    end
    pend_mask = {pm[31:1], 1'b0};
  end

  assign debug_wb_rf_wen   = rf_we;
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter: stimulus queues expected writes, a negedge
// monitor pops and compares every write the port presents.
module tb_rf_wport_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ws_rf_we;
  logic [4:0]  ws_rf_waddr;
  logic [31:0] ws_rf_wdata;
  logic [31:0] ws_pc;
  logic        lu_valid;
  logic        lu_ready;
  logic [3:0]  lu_we;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic [31:0] lu_pc;
  logic        ws_hold;
  logic [31:0] pend_mask;
  logic [3:0]  rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  rf_wport_arbiter #(.DEPTH(2), .MAX_WAIT(8)) dut (
    .clk(clk), .reset(reset),
    .ws_rf_we(ws_rf_we), .ws_rf_waddr(ws_rf_waddr), .ws_rf_wdata(ws_rf_wdata), .ws_pc(ws_pc),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_we(lu_we), .lu_waddr(lu_waddr),
    .lu_wdata(lu_wdata), .lu_pc(lu_pc),
    .ws_hold(ws_hold), .pend_mask(pend_mask),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ws(input logic [3:0] we, input logic [4:0] a, input logic [31:0] d,
                        input logic [31:0] pc);
    ws_rf_we = we; ws_rf_waddr = a; ws_rf_wdata = d; ws_pc = pc;
  endtask

  task automatic set_lu(input logic v, input logic [3:0] we, input logic [4:0] a,
                        input logic [31:0] d, input logic [31:0] pc);
    lu_valid = v; lu_we = we; lu_waddr = a; lu_wdata = d; lu_pc = pc;
  endtask

  task automatic expect_wr(input logic [3:0] we, input logic [4:0] a, input logic [31:0] d,
                           input logic [31:0] pc);
    wr_t e;
    e.we = we; e.addr = a; e.data = d; e.pc = pc;
    exp_q.push_back(e);
  endtask

  // Monitor: every presented write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rf_we != 4'h0) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got we=%h addr=%0d data=%h pc=%h expected none",
                 rf_we, rf_waddr, rf_wdata, debug_wb_pc);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (rf_we !== e.we || rf_waddr !== e.addr || rf_wdata !== e.data ||
            debug_wb_pc !== e.pc || debug_wb_rf_wen !== e.we ||
            debug_wb_rf_wnum !== e.addr || debug_wb_rf_wdata !== e.data) begin
          bad++;
          $display("FAIL write: got we=%h addr=%0d data=%h pc=%h dbg=%h/%0d/%h expected we=%h addr=%0d data=%h pc=%h",
                   rf_we, rf_waddr, rf_wdata, debug_wb_pc, debug_wb_rf_wen,
                   debug_wb_rf_wnum, debug_wb_rf_wdata, e.we, e.addr, e.data, e.pc);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    set_ws(4'h0, 5'd0, 32'h0, 32'h0);
    set_lu(1'b0, 4'h0, 5'd0, 32'h0, 32'h0);

    // Reset: WB write attempted during reset must not reach the port.
    cyc();
    set_ws(4'hf, 5'd3, 32'h99, 32'h4);
    #3;
    chk("rst_rf_we", 32'(rf_we), 32'h0);
    chk("rst_lu_ready", 32'(lu_ready), 32'h1);
    chk("rst_pend", pend_mask, 32'h0);
    chk("rst_hold", 32'(ws_hold), 32'h0);
    cyc();
    reset = 1'b0;
    set_ws(4'h0, 5'd0, 32'h0, 32'h0);

    // 1: WB-only pass-through
    cyc();
    set_ws(4'hf, 5'd5, 32'h1234, 32'hbfc00000);
    expect_wr(4'hf, 5'd5, 32'h1234, 32'hbfc00000);
    #3;
    chk("t1_rf_we", 32'(rf_we), 32'hf);
    chk("t1_waddr", 32'(rf_waddr), 32'd5);
    chk("t1_pc", debug_wb_pc, 32'hbfc00000);
    chk("t1_pend", pend_mask, 32'h0);
    chk("t1_hold", 32'(ws_hold), 32'h0);

    // 2: idle-port drain, one cycle latency, pend bit only in grant cycle
    cyc();
    set_ws(4'h0, 5'd0, 32'h0, 32'h0);
    set_lu(1'b1, 4'hf, 5'd7, 32'hdead, 32'h100);
    #3;
    chk("t2_no_bypass", 32'(rf_we), 32'h0);
    chk("t2_pend0", pend_mask, 32'h0);
    cyc();
    set_lu(1'b0, 4'h0, 5'd0, 32'h0, 32'h0);
    expect_wr(4'hf, 5'd7, 32'hdead, 32'h100);
    #3;
    chk("t2_pend_grant", pend_mask, 32'h80);
    chk("t2_rf_we", 32'(rf_we), 32'hf);
    cyc();
    #3;
    chk("t2_pend_after", pend_mask, 32'h0);

    // 3: full / backpressure, drain order 1,2,3
    cyc();
    set_ws(4'hf, 5'd1, 32'ha1, 32'h10);
    expect_wr(4'hf, 5'd1, 32'ha1, 32'h10);
    set_lu(1'b1, 4'h3, 5'd10, 32'he1, 32'h21);
    #3;
    chk("t3_ready0", 32'(lu_ready), 32'h1);
    cyc();
    set_ws(4'hf, 5'd2, 32'ha2, 32'h14);
    expect_wr(4'hf, 5'd2, 32'ha2, 32'h14);
    set_lu(1'b1, 4'hc, 5'd11, 32'he2, 32'h22);
    #3;
    chk("t3_ready1", 32'(lu_ready), 32'h1);
    cyc();
    set_ws(4'hf, 5'd3, 32'ha3, 32'h18);
    expect_wr(4'hf, 5'd3, 32'ha3, 32'h18);
    set_lu(1'b1, 4'h1, 5'd12, 32'he3, 32'h23);
    #3;
    chk("t3_full", 32'(lu_ready), 32'h0);
    chk("t3_pend_full", pend_mask, 32'h00000c00);
    cyc();
    set_ws(4'hf, 5'd4, 32'ha4, 32'h1c);
    expect_wr(4'hf, 5'd4, 32'ha4, 32'h1c);
    #3;
    chk("t3_still_full", 32'(lu_ready), 32'h0);
    cyc();
    set_ws(4'h0, 5'd0, 32'h0, 32'h0);
    expect_wr(4'h3, 5'd10, 32'he1, 32'h21);
    #3;
    chk("t3_pop_cycle_ready", 32'(lu_ready), 32'h0);
    cyc();
    expect_wr(4'hc, 5'd11, 32'he2, 32'h22);
    #3;
    chk("t3_ready_after_pop", 32'(lu_ready), 32'h1);
    chk("t3_pend_e2", pend_mask, 32'h00000800);
    cyc();
    set_lu(1'b0, 4'h0, 5'd0, 32'h0, 32'h0);
    expect_wr(4'h1, 5'd12, 32'he3, 32'h23);
    #3;
    chk("t3_pend_e3", pend_mask, 32'h00001000);
    cyc();
    #3;
    chk("t3_pend_empty", pend_mask, 32'h0);

    // 4: starvation -> ws_hold from cycle 9 after enqueue
    for (int i = 0; i <= 10; i++) begin
      cyc();
      set_ws(4'hf, 5'd2, 32'(i), 32'h300 + 32'(i));
      expect_wr(4'hf, 5'd2, 32'(i), 32'h300 + 32'(i));
      if (i == 0) set_lu(1'b1, 4'hf, 5'd9, 32'h55, 32'h200);
      else        set_lu(1'b0, 4'h0, 5'd0, 32'h0, 32'h0);
      #3;
      if (i == 8)  chk("t4_hold_c8", 32'(ws_hold), 32'h0);
      if (i == 9)  chk("t4_hold_c9", 32'(ws_hold), 32'h1);
      if (i == 10) chk("t4_hold_c10", 32'(ws_hold), 32'h1);
    end
    cyc();
    set_ws(4'h0, 5'd0, 32'h0, 32'h0);
    expect_wr(4'hf, 5'd9, 32'h55, 32'h200);
    #3;
    chk("t4_hold_grant", 32'(ws_hold), 32'h1);
    chk("t4_pend_grant", pend_mask, 32'h200);
    cyc();
    #3;
    chk("t4_hold_released", 32'(ws_hold), 32'h0);
    chk("t4_pend_clear", pend_mask, 32'h0);

    // 5: filtered pushes are accepted but not stored
    cyc();
    set_lu(1'b1, 4'hf, 5'd0, 32'h77, 32'h400);
    #3;
    chk("t5_ready_a", 32'(lu_ready), 32'h1);
    cyc();
    set_lu(1'b1, 4'h0, 5'd3, 32'h88, 32'h404);
    #3;
    chk("t5_ready_b", 32'(lu_ready), 32'h1);
    cyc();
    set_lu(1'b0, 4'h0, 5'd0, 32'h0, 32'h0);
    #3;
    chk("t5_pend", pend_mask, 32'h0);
    chk("t5_no_write", 32'(rf_we), 32'h0);
    chk("t5_ready_c", 32'(lu_ready), 32'h1);

    // 6: reset mid-drain discards queued entries
    cyc();
    set_ws(4'hf, 5'd1, 32'hb1, 32'h500);
    expect_wr(4'hf, 5'd1, 32'hb1, 32'h500);
    set_lu(1'b1, 4'hf, 5'd20, 32'hc1, 32'h600);
    cyc();
    set_ws(4'hf, 5'd2, 32'hb2, 32'h504);
    expect_wr(4'hf, 5'd2, 32'hb2, 32'h504);
    set_lu(1'b1, 4'hf, 5'd21, 32'hc2, 32'h604);
    cyc();
    set_ws(4'h0, 5'd0, 32'h0, 32'h0);
    set_lu(1'b0, 4'h0, 5'd0, 32'h0, 32'h0);
    reset = 1'b1;
    #3;
    chk("t6_pend_before", pend_mask, 32'h00300000);
    chk("t6_rst_rf_we", 32'(rf_we), 32'h0);
    cyc();
    reset = 1'b0;
    #3;
    chk("t6_rf_we", 32'(rf_we), 32'h0);
    chk("t6_lu_ready", 32'(lu_ready), 32'h1);
    chk("t6_pend", pend_mask, 32'h0);
    chk("t6_hold", 32'(ws_hold), 32'h0);
    cyc();
    cyc();
    #3;
    chk("t6_idle_rf_we", 32'(rf_we), 32'h0);
    cyc();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
